// File: rtl/fb_port_ctrl_if.sv
// fb_port_ctrl_if: host pixel channel, fill command channel and RAM port-B signals
interface fb_port_ctrl_if;
  logic [8:0] px_x;
  logic [7:0] px_y;
  logic       px_we, px_din, px_req, px_ack, px_dout;
  logic [8:0] fill_x0, fill_x1;
  logic [7:0] fill_y0, fill_y1;
  logic       fill_val, fill_start, fill_busy, fill_done;
  logic [8:0] x_b;
  logic [7:0] y_b;
  logic       read_b, write_b, in_b, out_b, rdy_b;
  modport master (
    input  px_x, px_y, px_we, px_din, px_req,
    input  fill_x0, fill_x1, fill_y0, fill_y1, fill_val, fill_start,
    input  out_b, rdy_b,
    output px_ack, px_dout, fill_busy, fill_done,
    output x_b, y_b, read_b, write_b, in_b
  );
  modport slave (
    output px_x, px_y, px_we, px_din, px_req,
    output fill_x0, fill_x1, fill_y0, fill_y1, fill_val, fill_start,
    output out_b, rdy_b,
    input  px_ack, px_dout, fill_busy, fill_done,
    input  x_b, y_b, read_b, write_b, in_b
  );
endinterface

// File: rtl/fb_port_ctrl.sv
// fb_port_ctrl: sole master of RAM port B, arbitrating host pixel ops against a rectangle fill engine
module fb_port_ctrl #(
  parameter int W = 320,
  parameter int H = 200
) (
  input logic clk,
  input logic rst,
  fb_port_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {PX, FILL} own_t;
  localparam logic [8:0] XM = 9'(W - 1);
  localparam logic [7:0] YM = 8'(H - 1);
  state_t state, state_n;
  own_t grant, prio;
  logic w1, op_we, fval, fempty;
  logic [8:0] fx, fx0, fx1, cx1;
  logic [7:0] fy, fy0, fy1, cy1;
  logic px_pend, px_oob, px_val, fill_pend, sel_fill, go, done_op, last;
  always_comb begin
    px_pend   = bus.px_req && !bus.px_ack;
    px_oob    = 32'(bus.px_x) >= W || 32'(bus.px_y) >= H;
    px_val    = px_pend && !px_oob;
    fill_pend = bus.fill_busy && !fempty && !bus.fill_done;
    sel_fill  = fill_pend && (!px_val || prio == FILL);
    go        = state == IDLE && bus.rdy_b && (px_val || fill_pend);
    done_op   = state == WAIT && !w1 && bus.rdy_b;
    last      = fx == fx1 && fy == fy1;
    cx1       = 32'(bus.fill_x1) > W - 1 ? XM : bus.fill_x1;
    cy1       = 32'(bus.fill_y1) > H - 1 ? YM : bus.fill_y1;
    state_n   = state == IDLE ? (go ? ISSUE : IDLE) :
                state == ISSUE ? WAIT : (done_op ? IDLE : WAIT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant         <= PX;
      prio          <= PX;
      w1            <= 1'b0;
      op_we         <= 1'b0;
      bus.read_b    <= 1'b0;
      bus.write_b   <= 1'b0;
      bus.in_b      <= 1'b0;
      bus.x_b       <= '0;
      bus.y_b       <= '0;
      bus.px_ack    <= 1'b0;
      bus.px_dout   <= 1'b0;
      bus.fill_busy <= 1'b0;
      bus.fill_done <= 1'b0;
      fx            <= '0;
      fy            <= '0;
      fx0           <= '0;
      fx1           <= '0;
      fy0           <= '0;
      fy1           <= '0;
      fval          <= 1'b0;
      fempty        <= 1'b0;
    end else begin
      bus.px_ack    <= 1'b0;
      bus.px_dout   <= 1'b0;
      bus.fill_done <= 1'b0;
      w1            <= state == ISSUE;
      if (state == ISSUE) begin
        bus.read_b  <= 1'b0;
        bus.write_b <= 1'b0;
      end
      if (go) begin
        grant       <= sel_fill ? FILL : PX;
        prio        <= sel_fill ? PX : FILL;
        bus.x_b     <= sel_fill ? fx : bus.px_x;
        bus.y_b     <= sel_fill ? fy : bus.px_y;
        bus.in_b    <= sel_fill ? fval : bus.px_din;
        op_we       <= sel_fill || bus.px_we;
        bus.read_b  <= !sel_fill && !bus.px_we;
        bus.write_b <= sel_fill || bus.px_we;
      end
      // out-of-range host ops complete without touching the RAM
      if (state == IDLE && px_pend && px_oob) bus.px_ack <= 1'b1;
      if (done_op && grant == PX) begin
        bus.px_ack  <= 1'b1;
        bus.px_dout <= !op_we && bus.out_b;
      end
      if (!bus.fill_busy && bus.fill_start) begin
        bus.fill_busy <= 1'b1;
        fx0    <= bus.fill_x0;
        fy0    <= bus.fill_y0;
        fx1    <= cx1;
        fy1    <= cy1;
        fx     <= bus.fill_x0;
        fy     <= bus.fill_y0;
        fval   <= bus.fill_val;
        fempty <= bus.fill_x0 > cx1 || bus.fill_y0 > cy1 ||
                  32'(bus.fill_x0) >= W || 32'(bus.fill_y0) >= H;
      end else if (bus.fill_busy && fempty) begin
        bus.fill_busy <= 1'b0;
        bus.fill_done <= 1'b1;
      end else if (bus.fill_done) begin
        bus.fill_busy <= 1'b0;
      end else if (done_op && grant == FILL) begin
        bus.fill_done <= last;
        fx <= fx == fx1 ? fx0 : fx + 9'd1;
        fy <= fx == fx1 ? fy + 8'd1 : fy;
      end
    end
endmodule

// File: tb/tb_fb_port_ctrl.sv
// tb_fb_port_ctrl: scoreboard bench with a RAM model on port B, run on a reduced 40x25 framebuffer
module tb_fb_port_ctrl;
  localparam int TW = 40;
  localparam int TH = 25;
  typedef logic [18:0] op_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fb_port_ctrl_if bus();
  fb_port_ctrl #(.W(TW), .H(TH)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  op_t host_q[$];
  op_t fill_q[$];
  logic px_q[$];
  logic mem [0:511][0:255];
  logic ref_mem [0:511][0:255];
  int n_chk = 0, n_err = 0, cyc = 0, n_stb = 0, n_wr = 0, n_done = 0, stall = 0, rdy_up = 0;
  logic lat_chk = 1'b0;
  logic [15:0] kind_sh = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // RAM model and output monitor, sampling on the falling edge
  initial begin
    int st_cnt;
    logic prev;
    op_t got, hold;
    logic [19:0] exp;
    st_cnt = 0;
    prev = 1'b0;
    hold = '0;
    bus.rdy_b = 1'b1;
    bus.out_b = 1'b0;
    for (int x = 0; x < 512; x++) for (int y = 0; y < 256; y++) mem[x][y] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st_cnt = 0;
        bus.rdy_b = 1'b1;
        prev = 1'b0;
      end else begin
        if (bus.read_b || bus.write_b) begin
          chk("rw_excl", 32'(bus.read_b & bus.write_b), 0);
          chk("one_cyc_strobe", 32'(prev), 0);
          got = {bus.write_b, bus.x_b, bus.y_b, bus.write_b & bus.in_b};
          kind_sh = {kind_sh[14:0], bus.write_b};
          n_stb++;
          if (bus.write_b) n_wr++;
          if (bus.write_b && fill_q.size() > 0) exp = {1'b1, fill_q.pop_front()};
          else if (host_q.size() > 0) exp = {1'b1, host_q.pop_front()};
          else exp = '0;
          chk("ram_op", 32'({1'b1, got}), 32'(exp));
          if (bus.write_b) mem[bus.x_b][bus.y_b] = bus.in_b;
          else bus.out_b = mem[bus.x_b][bus.y_b];
          hold = got;
          if (stall > 0) begin
            bus.rdy_b = 1'b0;
            st_cnt = stall;
          end
        end else if (st_cnt > 0) begin
          chk("addr_hold", 32'({bus.x_b, bus.y_b, hold[18] & bus.in_b}), 32'(hold[17:0]));
          st_cnt--;
          if (st_cnt == 0) begin
            bus.rdy_b = 1'b1;
            rdy_up = cyc;
          end
        end
        prev = bus.read_b || bus.write_b;
        if (bus.px_ack) begin
          exp = px_q.size() > 0 ? {19'd1, px_q.pop_front()} : '0;
          chk("px_dout", 32'({19'd1, bus.px_dout}), 32'(exp));
          if (lat_chk) chk("ack_latency", cyc - rdy_up, 1);
        end
        if (bus.fill_done) n_done++;
      end
    end
  end
  task automatic px_ops(input int n, input int x0, input int y, input logic we, input logic din);
    int x, t;
    for (int k = 0; k < n; k++) begin
      x = x0 + k;
      t = 0;
      if (x < TW && y < TH) begin
        host_q.push_back({we, 9'(x), 8'(y), we & din});
        px_q.push_back(we ? 1'b0 : ref_mem[x][y]);
        if (we) ref_mem[x][y] = din;
      end else px_q.push_back(1'b0);
      bus.px_x = 9'(x);
      bus.px_y = 8'(y);
      bus.px_we = we;
      bus.px_din = din;
      bus.px_req = 1'b1;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.px_ack && t < 300);
      chk("px_ack", 32'(bus.px_ack), 1);
      @(posedge clk);
      #1;
    end
    bus.px_req = 1'b0;
  endtask
  task automatic fill_run(input int x0, input int y0, input int x1, input int y1, input logic v);
    int cx1, cy1, n, t, w0, d0;
    cx1 = x1 > TW - 1 ? TW - 1 : x1;
    cy1 = y1 > TH - 1 ? TH - 1 : y1;
    n = 0;
    t = 0;
    w0 = n_wr;
    d0 = n_done;
    if (x0 <= cx1 && y0 <= cy1)
      for (int y = y0; y <= cy1; y++)
        for (int x = x0; x <= cx1; x++) begin
          fill_q.push_back({1'b1, 9'(x), 8'(y), v});
          ref_mem[x][y] = v;
          n++;
        end
    bus.fill_x0 = 9'(x0);
    bus.fill_y0 = 8'(y0);
    bus.fill_x1 = 9'(x1);
    bus.fill_y1 = 8'(y1);
    bus.fill_val = v;
    bus.fill_start = 1'b1;
    @(posedge clk);
    #1 bus.fill_start = 1'b0;
    @(negedge clk);
    chk("fill_busy_rise", 32'(bus.fill_busy), 1);
    do begin
      @(negedge clk);
      t++;
    end while (!bus.fill_done && t < 20 * n + 10);
    chk("fill_done", 32'(bus.fill_done), 1);
    chk("fill_writes", n_wr - w0, n);
    if (n == 0) begin
      chk("empty_done_lat", t, 1);
      chk("empty_busy_clr", 32'(bus.fill_busy), 0);
    end
    @(negedge clk);
    chk("fill_busy_clr", 32'(bus.fill_busy), 0);
    chk("fill_done_pulse", 32'(bus.fill_done), 0);
    @(posedge clk);
    #1;
    chk("fill_done_cnt", n_done - d0, 1);
  endtask
  initial begin
    int s0, d0, k, t;
    for (int x = 0; x < 512; x++) for (int y = 0; y < 256; y++) ref_mem[x][y] = 1'b0;
    bus.px_x = '0; bus.px_y = '0; bus.px_we = 1'b0; bus.px_din = 1'b0; bus.px_req = 1'b0;
    bus.fill_x0 = '0; bus.fill_x1 = '0; bus.fill_y0 = '0; bus.fill_y1 = '0;
    bus.fill_val = 1'b0; bus.fill_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'({bus.read_b, bus.write_b, bus.in_b, bus.x_b, bus.y_b,
        bus.px_ack, bus.px_dout, bus.fill_busy, bus.fill_done}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    stall = 3;
    lat_chk = 1'b1;
    s0 = n_stb;
    px_ops(1, 10, 5, 1'b1, 1'b1);
    stall = 0;
    lat_chk = 1'b0;
    chk("write_strobes", n_stb - s0, 1);
    px_ops(1, 10, 5, 1'b0, 1'b0);
    px_ops(2, 11, 5, 1'b0, 1'b0);
    fill_run(0, 0, 511, 255, 1'b1);
    px_ops(1, 39, 24, 1'b0, 1'b0);
    s0 = n_stb;
    px_ops(1, 40, 0, 1'b0, 1'b0);
    px_ops(1, 320, 0, 1'b0, 1'b0);
    px_ops(1, 5, 30, 1'b1, 1'b1);
    chk("oob_strobes", n_stb - s0, 0);
    kind_sh = '0;
    s0 = n_stb;
    fork
      fill_run(2, 3, 4, 4, 1'b0);
      px_ops(8, 20, 10, 1'b0, 1'b0);
    join
    chk("alt_count", n_stb - s0, 14);
    chk("alt_order", 32'(kind_sh[13:0]), 32'(14'b01010101010100));
    px_ops(1, 3, 3, 1'b0, 1'b0);
    px_ops(1, 5, 3, 1'b0, 1'b0);
    s0 = n_stb;
    fill_run(5, 0, 4, 3, 1'b0);
    fill_run(0, 30, 3, 40, 1'b0);
    fill_run(45, 0, 50, 0, 1'b0);
    chk("empty_strobes", n_stb - s0, 0);
    stall = 3;
    for (int x = 0; x < 10; x++) fill_q.push_back({1'b1, 9'(x), 8'd0, 1'b0});
    bus.fill_x0 = 9'd0; bus.fill_y0 = 8'd0; bus.fill_x1 = 9'd9; bus.fill_y1 = 8'd0;
    bus.fill_val = 1'b0;
    bus.fill_start = 1'b1;
    @(posedge clk);
    #1 bus.fill_start = 1'b0;
    k = 0;
    t = 0;
    while (k < 2 && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.write_b) k++;
    end
    chk("rst_setup", k, 2);
    d0 = n_done;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_abort", 32'({bus.read_b, bus.write_b, bus.fill_busy, bus.x_b, bus.y_b}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fill_q.delete();
    stall = 0;
    repeat (4) @(negedge clk);
    chk("no_done_after_rst", n_done - d0, 0);
    @(posedge clk);
    #1;
    fill_run(7, 8, 8, 8, 1'b0);
    px_ops(1, 7, 8, 1'b0, 1'b0);
    px_ops(1, 9, 8, 1'b0, 1'b0);
    chk("host_q_left", host_q.size(), 0);
    chk("fill_q_left", fill_q.size(), 0);
    chk("px_q_left", px_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
